// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR filter and its downstream packer.
// Holds the sample width, packing factor, FIFO depth and drop counter width.
package fir_pkg;

    localparam int DATA_W     = 8;
    localparam int PACK_N     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int DROP_CNT_W = 16;

    typedef logic signed [DATA_W-1:0]        sample_t;
    typedef logic        [DATA_W*PACK_N-1:0] word_t;
    typedef logic        [PACK_N-1:0]        keep_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO with extra-MSB pointers.
// Ports: clk, rst (sync, active high), push/din, pop/dout, full, empty.
module fir_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot on the same edge, so a full FIFO can accept.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = din;
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/fir_sample_packer.sv
// Packs PACK_N FIR samples per word into a FWFT FIFO on a valid/ready stream.
// Ports: clk, rst, i_valid/i_y/i_flush in; o_valid/o_ready/o_data/o_keep,
// o_drop_cnt out. Define FIR_PACK_DROP_CNT_EN to enable the drop counter.
module fir_sample_packer
    import fir_pkg::*;
#(
    parameter int DATA_W     = fir_pkg::DATA_W,
    parameter int PACK_N     = fir_pkg::PACK_N,
    parameter int FIFO_DEPTH = fir_pkg::FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [DATA_W-1:0]        i_y,
    input  logic                     i_flush,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [DATA_W*PACK_N-1:0] o_data,
    output logic [PACK_N-1:0]        o_keep,
    output logic [DROP_CNT_W-1:0]    o_drop_cnt
);

    localparam int LW = $clog2(PACK_N);
    localparam int WW = DATA_W * PACK_N;

    logic [LW-1:0]        lane_q, lane_d;
    logic [WW-1:0]        asm_q, asm_d;
    logic [WW-1:0]        word_w;
    logic [PACK_N-1:0]    keep_w;
    logic [LW:0]          fill_w;
    logic                 complete_w;
    logic                 push_w;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [WW+PACK_N-1:0] fifo_dout;

    // fill_w counts lanes holding data once the current sample lands.
    always_comb begin
        word_w = asm_q;
        if (i_valid) begin
            word_w[lane_q*DATA_W +: DATA_W] = i_y;
        end
        fill_w     = {1'b0, lane_q} + {{LW{1'b0}}, i_valid};
        complete_w = i_valid && (lane_q == LW'(PACK_N - 1));
        push_w     = complete_w || (i_flush && (fill_w != '0));
        keep_w     = '0;
        for (int k = 0; k < PACK_N; k++) begin
            keep_w[k] = ((LW+1)'(k) < fill_w);
        end
    end

    always_comb begin
        lane_d = lane_q;
        asm_d  = asm_q;
        if (push_w) begin
            lane_d = '0;
            asm_d  = '0;
        end else if (i_valid) begin
            lane_d = lane_q + 1'b1;
            asm_d  = word_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
            asm_q  <= '0;
        end else begin
            lane_q <= lane_d;
            asm_q  <= asm_d;
        end
    end

    fir_sync_fifo #(
        .WIDTH (WW + PACK_N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_w),
        .din   ({keep_w, word_w}),
        .pop   (o_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign o_valid          = !fifo_empty;
    assign {o_keep, o_data} = fifo_dout;

`ifdef FIR_PACK_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  drop_w;

    // Full implies o_valid, so o_ready alone decides whether a slot frees.
    assign drop_w = push_w && fifo_full && !o_ready;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_w && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    logic unused_full;

    assign unused_full = fifo_full;
    assign o_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_fir_sample_packer.sv
// Self-checking bench for fir_sample_packer: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_fir_sample_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [7:0]  i_y;
    logic        i_flush;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic [3:0]  o_keep;
    logic [15:0] o_drop_cnt;

    int checks = 0;
    int passes = 0;

    // Reference model: pending samples, FIFO contents {keep,data}, drops.
    logic [7:0]  m_pend[$];
    logic [35:0] m_q[$];
    int          m_drops = 0;

    always #5 clk = ~clk;

    fir_sample_packer dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_y        (i_y),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_keep     (o_keep),
        .o_drop_cnt (o_drop_cnt)
    );

    function automatic logic [15:0] exp_drops();
`ifdef FIR_PACK_DROP_CNT_EN
        return 16'(m_drops);
`else
        return 16'd0;
`endif
    endfunction

    // Apply one cycle of inputs, advance the model at the edge, settle #1.
    task automatic drive(input logic v, input logic [7:0] y,
                         input logic f, input logic r);
        logic        was_full;
        logic        popped;
        logic [31:0] d;
        logic [3:0]  k;
        i_valid = v;
        i_y     = y;
        i_flush = f;
        o_ready = r;
        @(posedge clk);
        if (rst) begin
            m_pend.delete();
            m_q.delete();
            m_drops = 0;
        end else begin
            was_full = (m_q.size() == 4);
            popped   = (m_q.size() > 0) && r;
            if (popped) void'(m_q.pop_front());
            if (v) m_pend.push_back(y);
            if (m_pend.size() == 4 || (f && m_pend.size() > 0)) begin
                d = '0;
                k = '0;
                foreach (m_pend[i]) begin
                    d[i*8 +: 8] = m_pend[i];
                    k[i]        = 1'b1;
                end
                m_pend.delete();
                if (was_full && !popped) begin
                    if (m_drops < 65535) m_drops++;
                end else begin
                    m_q.push_back({k, d});
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 8'h00, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 8'h55, 1, 0);
        drive(1, 8'h66, 0, 1);
        rst = 1'b0;
        checks++;
        if (o_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_valid);
        else passes++;
        checks++;
        if (o_data !== 32'h0) $display("FAIL reset_data got %h want 0", o_data);
        else passes++;
        checks++;
        if (o_keep !== 4'h0) $display("FAIL reset_keep got %h want 0", o_keep);
        else passes++;
        checks++;
        if (o_drop_cnt !== 16'h0)
            $display("FAIL reset_drop got %h want 0", o_drop_cnt);
        else passes++;
    endtask

    task automatic test_basic_pack();
        drive(1, 8'd1, 0, 1);
        drive(1, 8'hFA, 0, 1);
        drive(1, 8'd10, 0, 1);
        drive(1, 8'd2, 0, 1);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 32'h020AFA01 || o_keep !== 4'hF)
            $display("FAIL basic_pack got v=%b d=%h k=%h want v=1 d=020afa01 k=f",
                     o_valid, o_data, o_keep);
        else passes++;
        drive(0, 8'h00, 0, 1);
        checks++;
        if (o_valid !== 1'b0) $display("FAIL basic_pop got v=%b want 0", o_valid);
        else passes++;
    endtask

    task automatic test_partial_flush();
        drive(1, 8'd1, 0, 1);
        drive(1, 8'hFA, 0, 1);
        drive(0, 8'h00, 1, 1);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 32'h0000FA01 || o_keep !== 4'h3)
            $display("FAIL partial_flush got v=%b d=%h k=%h want v=1 d=0000fa01 k=3",
                     o_valid, o_data, o_keep);
        else passes++;
        drive(0, 8'h00, 1, 1);
        checks++;
        if (o_valid !== 1'b0)
            $display("FAIL empty_flush got v=%b want 0", o_valid);
        else passes++;
    endtask

    task automatic test_overflow();
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 20; i++) drive(1, 8'(i + 1), 0, 0);
        checks++;
        if (o_drop_cnt !== exp_drops() || exp_drops() !== 16'(m_drops > 0 ? 1 : 0)
            && o_drop_cnt !== 16'd0)
            $display("FAIL overflow_drop got %0d want %0d", o_drop_cnt, exp_drops());
        else passes++;
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(4*n + k + 1);
            checks++;
            if (o_valid !== 1'b1 || o_data !== w || o_keep !== 4'hF)
                $display("FAIL overflow_drain%0d got v=%b d=%h want v=1 d=%h",
                         n, o_valid, o_data, w);
            else passes++;
            drive(0, 8'h00, 0, 1);
        end
        checks++;
        if (o_valid !== 1'b0)
            $display("FAIL overflow_empty got v=%b want 0", o_valid);
        else passes++;
    endtask

    task automatic test_full_pop();
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 16; i++) drive(1, 8'(100 + i), 0, 0);
        for (int i = 16; i < 19; i++) drive(1, 8'(100 + i), 0, 0);
        drive(1, 8'(119), 0, 1);
        checks++;
        if (o_drop_cnt !== 16'd0)
            $display("FAIL full_pop_drop got %0d want 0", o_drop_cnt);
        else passes++;
        for (int n = 1; n < 5; n++) begin
            for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(100 + 4*n + k);
            checks++;
            if (o_valid !== 1'b1 || o_data !== w)
                $display("FAIL full_pop_word%0d got v=%b d=%h want v=1 d=%h",
                         n, o_valid, o_data, w);
            else passes++;
            drive(0, 8'h00, 0, 1);
        end
        checks++;
        if (o_valid !== 1'b0)
            $display("FAIL full_pop_empty got v=%b want 0", o_valid);
        else passes++;
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        drive(1, 8'd7, 0, 0);
        drive(1, 8'd8, 0, 0);
        do_reset();
        drive(1, 8'd4, 0, 0);
        drive(1, 8'hFC, 0, 0);
        drive(1, 8'd10, 0, 0);
        drive(1, 8'd2, 0, 0);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 32'h020AFC04 || o_keep !== 4'hF)
            $display("FAIL reset_mid_word got v=%b d=%h k=%h want v=1 d=020afc04 k=f",
                     o_valid, o_data, o_keep);
        else passes++;
        checks++;
        if (o_drop_cnt !== 16'd0)
            $display("FAIL reset_mid_drop got %0d want 0", o_drop_cnt);
        else passes++;
        drive(0, 8'h00, 0, 1);
        checks++;
        if (o_valid !== 1'b0)
            $display("FAIL reset_mid_single got v=%b want 0", o_valid);
        else passes++;
    endtask

    task automatic test_flush_coincide();
        do_reset();
        drive(1, 8'd1, 0, 0);
        drive(1, 8'd2, 0, 0);
        drive(1, 8'd3, 0, 0);
        drive(1, 8'd4, 1, 0);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 32'h04030201 || o_keep !== 4'hF)
            $display("FAIL flush_coincide got v=%b d=%h k=%h want v=1 d=04030201 k=f",
                     o_valid, o_data, o_keep);
        else passes++;
        drive(0, 8'h00, 0, 1);
        checks++;
        if (o_valid !== 1'b0)
            $display("FAIL flush_coincide_single got v=%b want 0", o_valid);
        else passes++;
    endtask

    task automatic test_random();
        logic [35:0] head;
        int          errs;
        do_reset();
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0));
            head = (m_q.size() > 0) ? m_q[0] : 36'h0;
            checks++;
            if (o_valid !== (m_q.size() > 0) || o_data !== head[31:0] ||
                o_keep !== head[35:32] || o_drop_cnt !== exp_drops()) begin
                if (errs < 10)
                    $display("FAIL random_c%0d got v=%b d=%h k=%h dc=%0d want v=%b d=%h k=%h dc=%0d",
                             c, o_valid, o_data, o_keep, o_drop_cnt,
                             m_q.size() > 0, head[31:0], head[35:32], exp_drops());
                errs++;
            end else passes++;
        end
    endtask

    initial begin
        rst     = 1'b0;
        i_valid = 1'b0;
        i_y     = 8'h00;
        i_flush = 1'b0;
        o_ready = 1'b0;
        test_reset();
        test_basic_pack();
        test_partial_flush();
        test_overflow();
        test_full_pop();
        test_reset_mid_word();
        test_flush_coincide();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
